// File: rtl/wasm_typed_stack.sv
// wasm_typed_stack: typed operand stack for the WebAssembly CPU.
// Each entry holds a value and a type tag (0=i32, 1=i64, 2=f32, 3=f64).
// Operations: PUSH, POP, DROP (single cycle) and SELECT (three-cycle FSM).
// Underflow, overflow and type mismatch raise a sticky trap that blocks
// further operations until reset.
// Optional build macro WASM_SELECT_TYPECHECK_EN: when defined, SELECT
// requires an i32 condition and matching operand tags; when undefined only
// the operand count is checked and the chosen entry keeps its own tag.
module wasm_typed_stack #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 64,
  parameter int TAG_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      in_value,
  input  logic [TAG_W-1:0]      in_type,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_value,
  output logic [TAG_W-1:0]      out_type,
  output logic [WIDTH-1:0]      top_value,
  output logic [TAG_W-1:0]      top_type,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [3:0]            trap
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_TWO   = (DEPTH_LOG2+1)'(2);
  localparam logic [DEPTH_LOG2:0]   CNT_THREE = (DEPTH_LOG2+1)'(3);
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] IDX_TWO   = DEPTH_LOG2'(2);
  localparam logic [DEPTH_LOG2-1:0] IDX_THREE = DEPTH_LOG2'(3);

  localparam logic [3:0] TRAP_NONE      = 4'd0;
  localparam logic [3:0] TRAP_UNDERFLOW = 4'd1;
  localparam logic [3:0] TRAP_OVERFLOW  = 4'd2;
  localparam logic [3:0] TRAP_MISMATCH  = 4'd3;

  typedef enum logic [1:0] {
    OP_PUSH   = 2'd0,
    OP_POP    = 2'd1,
    OP_DROP   = 2'd2,
    OP_SELECT = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    S_COND  = 2'd1,
    S_OPS   = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Stack storage
  logic [WIDTH-1:0] mem_value [DEPTH];
  logic [TAG_W-1:0] mem_type  [DEPTH];

  state_t           state;
  logic             cond_true;
  logic [WIDTH-1:0] sel_value;
  logic [TAG_W-1:0] sel_type;

  // Slot indices relative to the current count; the low bits wrap naturally
  // so a full stack (count == DEPTH) still addresses its top as DEPTH-1.
  logic [DEPTH_LOG2-1:0] idx_top;
  logic [DEPTH_LOG2-1:0] idx_m1;
  logic [DEPTH_LOG2-1:0] idx_m2;
  logic [DEPTH_LOG2-1:0] idx_m3;

  assign idx_top = count[DEPTH_LOG2-1:0];
  assign idx_m1  = idx_top - IDX_ONE;
  assign idx_m2  = idx_top - IDX_TWO;
  assign idx_m3  = idx_top - IDX_THREE;

  // SELECT operands: c is the top entry, b below it, a deepest.
  logic [31:0]      c_low32;
  logic [WIDTH-1:0] a_value;
  logic [TAG_W-1:0] a_type;
  logic [WIDTH-1:0] b_value;
  logic [TAG_W-1:0] b_type;

  assign c_low32 = mem_value[idx_m1][31:0];
  assign a_value = mem_value[idx_m3];
  assign a_type  = mem_type[idx_m3];
  assign b_value = mem_value[idx_m2];
  assign b_type  = mem_type[idx_m2];

  logic cond_type_ok;
  logic ab_type_ok;

`ifdef WASM_SELECT_TYPECHECK_EN
  localparam logic [TAG_W-1:0] TAG_I32 = '0;
  logic [TAG_W-1:0] c_type;
  assign c_type       = mem_type[idx_m1];
  assign cond_type_ok = (c_type == TAG_I32);
  assign ab_type_ok   = (a_type == b_type);
`else
  assign cond_type_ok = 1'b1;
  assign ab_type_ok   = 1'b1;
`endif

  logic accept;
  logic push_we;
  logic sel_we;

  assign accept  = op_valid && op_ready;
  assign push_we = accept && (op_t'(op) == OP_PUSH) && (count != CNT_FULL);
  assign sel_we  = (state == S_WRITE);

  // Stack array writes: PUSH appends at the top, SELECT overwrites slot a.
  // NOTE: the array has no reset; count alone defines which slots are live,
  // so clearing the storage would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (push_we) begin
        mem_value[idx_top] <= in_value;
        mem_type[idx_top]  <= in_type;
      end else if (sel_we) begin
        mem_value[idx_m3] <= sel_value;
        mem_type[idx_m3]  <= sel_type;
      end
    end
  end

  // Control FSM plus registered count, top-of-stack view, pop result and trap.
  // NOTE: all state here uses non-blocking assignments so every branch reads
  // the pre-edge values of count/top_value, matching the array read ports.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      empty     <= 1'b1;
      op_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_value <= '0;
      out_type  <= '0;
      top_value <= '0;
      top_type  <= '0;
      trap      <= TRAP_NONE;
      cond_true <= 1'b0;
      sel_value <= '0;
      sel_type  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_t'(op))
              OP_PUSH: begin
                if (count == CNT_FULL) begin
                  trap     <= TRAP_OVERFLOW;
                  op_ready <= 1'b0;
                end else begin
                  count     <= count + CNT_ONE;
                  top_value <= in_value;
                  top_type  <= in_type;
                  empty     <= 1'b0;
                end
              end
              OP_POP, OP_DROP: begin
                if (empty) begin
                  trap     <= TRAP_UNDERFLOW;
                  op_ready <= 1'b0;
                end else begin
                  count <= count - CNT_ONE;
                  if (op_t'(op) == OP_POP) begin
                    out_valid <= 1'b1;
                    out_value <= top_value;
                    out_type  <= top_type;
                  end
                  if (count == CNT_ONE) begin
                    top_value <= '0;
                    top_type  <= '0;
                    empty     <= 1'b1;
                  end else begin
                    top_value <= b_value;
                    top_type  <= b_type;
                  end
                end
              end
              OP_SELECT: begin
                state    <= S_COND;
                op_ready <= 1'b0;
              end
            endcase
          end
        end
        S_COND: begin
          if (count < CNT_THREE) begin
            trap  <= TRAP_UNDERFLOW;
            state <= IDLE;
          end else if (!cond_type_ok) begin
            trap  <= TRAP_MISMATCH;
            state <= IDLE;
          end else begin
            cond_true <= (c_low32 != 32'd0);
            state     <= S_OPS;
          end
        end
        S_OPS: begin
          if (!ab_type_ok) begin
            trap  <= TRAP_MISMATCH;
            state <= IDLE;
          end else begin
            sel_value <= cond_true ? a_value : b_value;
            sel_type  <= cond_true ? a_type  : b_type;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          count     <= count - CNT_TWO;
          top_value <= sel_value;
          top_type  <= sel_type;
          empty     <= 1'b0;
          op_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_typed_stack.sv
// Self-checking bench for wasm_typed_stack: directed steps with a scoreboard
// of expected POP results consumed by an out_valid monitor.
module tb_wasm_typed_stack;

  localparam int DEPTH_LOG2 = 4;
  localparam int WIDTH      = 64;
  localparam int TAG_W      = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  localparam logic [1:0] T_I32 = 2'd0;
  localparam logic [1:0] T_I64 = 2'd1;
  localparam logic [1:0] T_F32 = 2'd2;

  localparam logic [1:0] OP_PUSH   = 2'd0;
  localparam logic [1:0] OP_POP    = 2'd1;
  localparam logic [1:0] OP_DROP   = 2'd2;
  localparam logic [1:0] OP_SELECT = 2'd3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 op_valid = 1'b0;
  logic                 op_ready;
  logic [1:0]           op = 2'd0;
  logic [WIDTH-1:0]     in_value = '0;
  logic [TAG_W-1:0]     in_type = '0;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_value;
  logic [TAG_W-1:0]     out_type;
  logic [WIDTH-1:0]     top_value;
  logic [TAG_W-1:0]     top_type;
  logic                 empty;
  logic [DEPTH_LOG2:0]  count;
  logic [3:0]           trap;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [63:0] value;
    logic [1:0]  ty;
  } exp_t;

  exp_t sb[$];
  exp_t sb_head;

  wasm_typed_stack #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH),
    .TAG_W      (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .in_value  (in_value),
    .in_type   (in_type),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_type  (out_type),
    .top_value (top_value),
    .top_type  (top_type),
    .empty     (empty),
    .count     (count),
    .trap      (trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One operation: driven after a falling edge, accepted on the next rising edge.
  task automatic do_op(input logic [1:0] o, input logic [63:0] v, input logic [1:0] t);
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    in_value = v;
    in_type  = t;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic push(input logic [63:0] v, input logic [1:0] t);
    do_op(OP_PUSH, v, t);
  endtask

  // POP with its expected result queued for the monitor.
  task automatic pop_expect(input logic [63:0] v, input logic [1:0] t);
    sb.push_back('{value: v, ty: t});
    do_op(OP_POP, 64'd0, 2'd0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every out_valid pulse must match the oldest queued POP.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        check("out_valid_unexpected", 64'(out_valid), 64'd0);
      end else begin
        sb_head = sb.pop_front();
        check("pop_value", out_value, sb_head.value);
        check("pop_type", 64'(out_type), 64'(sb_head.ty));
      end
    end
  end

  initial begin
    // Reset values
    wait_cycles(2);
    reset = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_op_ready", 64'(op_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_value", out_value, 64'd0);
    check("rst_out_type", 64'(out_type), 64'd0);
    check("rst_top_value", top_value, 64'd0);
    check("rst_top_type", 64'(top_type), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);

    // PUSH 5, PUSH 7, POP -> 7
    push(64'd5, T_I32);
    push(64'd7, T_I32);
    check("push2_count", 64'(count), 64'd2);
    check("push2_top", top_value, 64'd7);
    pop_expect(64'd7, T_I32);
    check("pop_count", 64'(count), 64'd1);
    check("pop_top", top_value, 64'd5);
    check("pop_op_ready", 64'(op_ready), 64'd1);

    // DROP removes without an out_valid pulse
    push(64'h1_0000_0003, T_I64);
    push(64'd4, T_F32);
    do_op(OP_DROP, 64'd0, 2'd0);
    check("drop_count", 64'(count), 64'd2);
    check("drop_top", top_value, 64'h1_0000_0003);
    check("drop_top_type", 64'(top_type), 64'(T_I64));
    do_op(OP_DROP, 64'd0, 2'd0);
    do_op(OP_DROP, 64'd0, 2'd0);
    check("drop_empty", 64'(empty), 64'd1);
    check("drop_empty_top", top_value, 64'd0);

    // SELECT cond != 0 -> a (deep)
    push(64'd10, T_I32);
    push(64'd20, T_I32);
    push(64'd1, T_I32);
    do_op(OP_SELECT, 64'd0, 2'd0);
    check("sel1_busy", 64'(op_ready), 64'd0);
    wait_cycles(2);
    check("sel1_latency_count", 64'(count), 64'd3);
    wait_cycles(1);
    check("sel1_count", 64'(count), 64'd1);
    check("sel1_top", top_value, 64'd10);
    check("sel1_ready", 64'(op_ready), 64'd1);
    pop_expect(64'd10, T_I32);

    // SELECT cond == 0 (upper bits set, low 32 bits zero) -> b
    push(64'd10, T_I32);
    push(64'd20, T_I32);
    push(64'h5_0000_0000, T_I32);
    do_op(OP_SELECT, 64'd0, 2'd0);
    wait_cycles(3);
    check("sel0_count", 64'(count), 64'd1);
    check("sel0_top", top_value, 64'd20);
    pop_expect(64'd20, T_I32);

    // SELECT with a/b tag mismatch
    push(64'd10, T_I32);
    push(64'd20, T_I64);
    push(64'd1, T_I32);
    do_op(OP_SELECT, 64'd0, 2'd0);
    wait_cycles(3);
`ifdef WASM_SELECT_TYPECHECK_EN
    check("ab_mis_trap", 64'(trap), 64'd3);
    check("ab_mis_count", 64'(count), 64'd3);
    check("ab_mis_top", top_value, 64'd1);
    check("ab_mis_ready", 64'(op_ready), 64'd0);
`else
    check("ab_nochk_trap", 64'(trap), 64'd0);
    check("ab_nochk_count", 64'(count), 64'd1);
    check("ab_nochk_top", top_value, 64'd10);
    check("ab_nochk_type", 64'(top_type), 64'(T_I32));
`endif
    apply_reset();

    // SELECT with a non-i32 condition
    push(64'd10, T_I32);
    push(64'd20, T_I32);
    push(64'd0, T_F32);
    do_op(OP_SELECT, 64'd0, 2'd0);
    wait_cycles(3);
`ifdef WASM_SELECT_TYPECHECK_EN
    check("c_mis_trap", 64'(trap), 64'd3);
    check("c_mis_count", 64'(count), 64'd3);
    check("c_mis_top_type", 64'(top_type), 64'(T_F32));
`else
    check("c_nochk_trap", 64'(trap), 64'd0);
    check("c_nochk_count", 64'(count), 64'd1);
    check("c_nochk_top", top_value, 64'd20);
`endif
    apply_reset();

    // Overflow: DEPTH pushes fit, one more traps
    for (int i = 0; i < DEPTH; i++) push(64'(i + 100), T_I64);
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_trap", 64'(trap), 64'd0);
    push(64'd999, T_I64);
    check("ovf_trap", 64'(trap), 64'd2);
    check("ovf_count", 64'(count), 64'(DEPTH));
    check("ovf_top", top_value, 64'(DEPTH - 1 + 100));
    check("ovf_ready", 64'(op_ready), 64'd0);
    // Trap is sticky: a further POP is ignored
    do_op(OP_POP, 64'd0, 2'd0);
    check("ovf_sticky_trap", 64'(trap), 64'd2);
    check("ovf_sticky_count", 64'(count), 64'(DEPTH));
    apply_reset();

    // Underflow on empty POP
    do_op(OP_POP, 64'd0, 2'd0);
    check("udf_pop_trap", 64'(trap), 64'd1);
    check("udf_pop_count", 64'(count), 64'd0);
    apply_reset();

    // SELECT with only two entries
    push(64'd11, T_I32);
    push(64'd22, T_I32);
    do_op(OP_SELECT, 64'd0, 2'd0);
    wait_cycles(3);
    check("udf_sel_trap", 64'(trap), 64'd1);
    check("udf_sel_count", 64'(count), 64'd2);
    check("udf_sel_top", top_value, 64'd22);
    apply_reset();

    // Reset during S_OPS of a valid SELECT
    push(64'd10, T_I32);
    push(64'd20, T_I32);
    push(64'd1, T_I32);
    do_op(OP_SELECT, 64'd0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);
    check("midrst_ready", 64'(op_ready), 64'd1);
    check("midrst_trap", 64'(trap), 64'd0);
    wait_cycles(4);
    check("midrst_settled_count", 64'(count), 64'd0);

    // Stack still usable after the aborted SELECT
    push(64'd42, T_F32);
    pop_expect(64'd42, T_F32);
    wait_cycles(2);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wasm_typed_stack.md
Name: wasm_typed_stack

Overview:
- Parametrised operand stack for the WebAssembly CPU; every entry carries a value and a type tag.
- Executes PUSH, POP, DROP and SELECT against the stack, with type checking of operands.
- Raises a sticky trap on underflow, overflow or type mismatch.
- Sits between the CPU decoder and ALU; `result`/`result_empty` in the CPU are driven from its top-of-stack outputs.

Parameters:
- DEPTH_LOG2, 4: stack holds 2**DEPTH_LOG2 entries.
- WIDTH, 64: value width in bits; i32/f32 use the low 32 bits, upper bits are zero.
- TAG_W, 2: type tag width; encoding 0=i32, 1=i64, 2=f32, 3=f64.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- op_valid  input  1  operation request.
- op_ready  output  1  unit idle, can accept an operation.
- op  input  2  operation: 0=PUSH, 1=POP, 2=DROP, 3=SELECT.
- in_value  input  WIDTH  PUSH value.
- in_type  input  TAG_W  PUSH type tag.
- out_valid  output  1  one-cycle pulse: POP result valid.
- out_value  output  WIDTH  popped value.
- out_type  output  TAG_W  popped type.
- top_value  output  WIDTH  current top entry; 0 when empty.
- top_type  output  TAG_W  current top tag.
- empty  output  1  stack empty.
- count  output  DEPTH_LOG2+1  number of entries.
- trap  output  4  0=none, 1=underflow, 2=overflow, 3=types mismatch; sticky.

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-high.
- Reset values: count=0, empty=1, op_ready=1, out_valid=0, out_value=0, out_type=0, top_value=0, top_type=0, trap=0, FSM=IDLE.
- Reset mid-operation aborts the operation with no partial writes.
- Handshake: an operation is accepted when op_valid && op_ready on a rising clk edge. op_ready=0 while busy or when trap!=0.
- PUSH:
  - count<DEPTH: write entry, count+1, op_ready stays 1 (1-cycle op).
  - count==DEPTH: trap=2, stack unchanged.
- POP:
  - count>=1: out_value/out_type registered and out_valid pulses the cycle after acceptance; count-1.
  - count==0: trap=1.
- DROP: as POP but no out_valid. count==0 gives trap=1.
- SELECT follows WebAssembly semantics: operands are a (deep), b, c (top). Result is a if c!=0, else b. c is compared on its low 32 bits.
  - FSM states: IDLE -> S_COND -> S_OPS -> S_WRITE -> IDLE. op_ready=0 in the three non-IDLE states; latency is 3 cycles from acceptance to updated top.
  - S_COND: check count>=3, else trap=1. Check tag(c)==i32, else trap=3. Latch c.
  - S_OPS: read a and b. Require tag(a)==tag(b), else trap=3.
  - S_WRITE: overwrite slot of a with the chosen entry; count-2.
  - On any trap: the FSM returns to IDLE and the stack contents and count are unchanged from before the SELECT.
- Trap behaviour: the first trap code wins and is held until reset. Further op_valid is ignored.
- Derived outputs: top_value/top_type/empty/count are registered views of the stack state, updated in the same cycle count changes.
- Pointer arithmetic: unsigned, DEPTH_LOG2+1 bits; no wrap-around permitted (overflow/underflow trap instead).
- op_valid with an illegal encoding cannot occur (2-bit op is fully decoded).

Optional Feature:
- Macro: WASM_SELECT_TYPECHECK_EN.
- Defined: full type checks in SELECT as described above (condition must be i32, tag(a)==tag(b)).
- Undefined:
  - Only the count>=3 check is performed.
  - Tags are not compared; the chosen entry's own tag is written.
  - trap=3 is never raised.
  - FSM timing is unchanged (still 3 cycles).

Test Plan:
- Reset, then PUSH i32 5, PUSH i32 7, POP -> out_valid pulse with out_value=7, out_type=0; count=1, top_value=5.
- PUSH i32 10, i32 20, i32 1, SELECT -> after 3 cycles count=1, top_value=10. Repeat with cond 0 -> top_value=20.
- PUSH i32 10, i64 20, i32 1, SELECT -> trap=3, count=3, top_value=1, op_ready=0. Without WASM_SELECT_TYPECHECK_EN: top_value=10, trap=0.
- PUSH i32 10, i32 20, f32 0, SELECT -> trap=3 (condition not i32); stack unchanged.
- Fill 16 entries (DEPTH_LOG2=4), 17th PUSH -> trap=2, count=16. After reset, POP on empty -> trap=1. SELECT with count=2 -> trap=1.
- Assert reset during S_OPS of a valid SELECT -> next cycle count=0, empty=1, op_ready=1, trap=0.
